// File: rtl/aor3000_exception_sequencer.sv
// Picks one exception/interrupt from the memory stage, pulses exc_start a cycle later with
// code/EPC/BD/vector, then holds pipeline_flush for FLUSH_CYCLES more cycles before re-arming.
module aor3000_exception_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  interrupt_vector_i,
  input  logic        sr_ie_i,
  input  logic [7:0]  sr_im_i,
  input  logic        sr_bev_i,
  input  logic [1:0]  cause_ip_sw_i,
  input  logic        mem_stall_i,
  input  logic [6:0]  mem_exc_i,
  input  logic [1:0]  mem_branched_i,
  input  logic [31:0] mem_pc_i,
  input  logic [31:0] mem_branch_address_i,
  input  logic [31:0] mem_address_i,
  output logic        exc_start_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] exc_epc_o,
  output logic        exc_bd_o,
  output logic [31:0] exc_vector_o,
  output logic [31:0] exc_badvaddr_o,
  output logic        exc_badvaddr_we_o,
  output logic        pipeline_flush_o,
  output logic        irq_pending_o
);

  typedef enum logic [1:0] {IDLE, ENTRY, FLUSH} state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [4:0]                  code_q, code_d;
  logic [31:0]                 epc_q, epc_d;
  logic                        bd_q, bd_d;
  logic [31:0]                 vector_q, vector_d;
  logic [31:0]                 badv_q, badv_d;
  logic                        badv_we_q, badv_we_d;

  logic                        sync_evt, irq_evt;
  logic [4:0]                  sync_code;
  logic [31:0]                 epc_calc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= interrupt_vector_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign irq_pending_o = sr_ie_i & |({sync_q[SYNC_STAGES-1], cause_ip_sw_i} & sr_im_i);

  assign sync_evt = ~mem_stall_i & (|mem_exc_i);
  assign irq_evt  = ~mem_stall_i & ~(|mem_exc_i) & irq_pending_o;

  // Highest-numbered mem_exc bit wins: address errors first, overflow last.
  always_comb begin
    sync_code = 5'd12;
    if      (mem_exc_i[6]) sync_code = 5'd4;
    else if (mem_exc_i[5]) sync_code = 5'd5;
    else if (mem_exc_i[4]) sync_code = 5'd8;
    else if (mem_exc_i[3]) sync_code = 5'd9;
    else if (mem_exc_i[2]) sync_code = 5'd10;
    else if (mem_exc_i[1]) sync_code = 5'd11;
  end

  // Interrupts resume at the instruction not yet executed; faults point back at the faulting one.
  always_comb begin
    epc_calc = mem_pc_i - 32'd4;
    if (irq_evt && mem_branched_i == 2'd2)      epc_calc = mem_branch_address_i;
    else if (irq_evt && mem_branched_i == 2'd0) epc_calc = mem_pc_i;
    else if (mem_branched_i == 2'd2)            epc_calc = mem_pc_i - 32'd8;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    epc_d     = epc_q;
    bd_d      = bd_q;
    vector_d  = vector_q;
    badv_d    = badv_q;
    badv_we_d = badv_we_q;
    case (state_q)
      IDLE: begin
        if (sync_evt || irq_evt) begin
          state_d   = ENTRY;
          code_d    = sync_evt ? sync_code : 5'd0;
          epc_d     = epc_calc;
          bd_d      = (sync_evt && mem_branched_i == 2'd2) || (irq_evt && mem_branched_i == 2'd1);
          vector_d  = sr_bev_i ? 32'hBFC0_0180 : 32'h8000_0080;
          badv_d    = mem_address_i;
          badv_we_d = sync_evt && (mem_exc_i[6] || mem_exc_i[5]);
        end
      end
      ENTRY: begin
        state_d = FLUSH;
        cnt_d   = 4'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      code_q    <= '0;
      epc_q     <= '0;
      bd_q      <= 1'b0;
      vector_q  <= '0;
      badv_q    <= '0;
      badv_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      epc_q     <= epc_d;
      bd_q      <= bd_d;
      vector_q  <= vector_d;
      badv_q    <= badv_d;
      badv_we_q <= badv_we_d;
    end
  end

  assign exc_start_o       = (state_q == ENTRY);
  assign exc_badvaddr_we_o = exc_start_o & badv_we_q;
  assign pipeline_flush_o  = (state_q != IDLE);
  assign exc_code_o        = code_q;
  assign exc_epc_o         = epc_q;
  assign exc_bd_o          = bd_q;
  assign exc_vector_o      = vector_q;
  assign exc_badvaddr_o    = badv_q;

endmodule

// File: tb/tb_aor3000_exception_sequencer.sv
// Directed bench for the exception sequencer: vector table of single events plus
// hand-written sequences for stall, flush-window, level interrupt and reset corners.
module tb_aor3000_exception_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  interrupt_vector;
  logic        sr_ie, sr_bev, mem_stall;
  logic [7:0]  sr_im;
  logic [1:0]  cause_ip_sw, mem_branched;
  logic [6:0]  mem_exc;
  logic [31:0] mem_pc, mem_branch_address, mem_address;
  logic        exc_start, exc_bd, exc_badvaddr_we, pipeline_flush, irq_pending;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_vector, exc_badvaddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aor3000_exception_sequencer #(.FLUSH_CYCLES(2), .SYNC_STAGES(2)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .interrupt_vector_i   (interrupt_vector),
    .sr_ie_i              (sr_ie),
    .sr_im_i              (sr_im),
    .sr_bev_i             (sr_bev),
    .cause_ip_sw_i        (cause_ip_sw),
    .mem_stall_i          (mem_stall),
    .mem_exc_i            (mem_exc),
    .mem_branched_i       (mem_branched),
    .mem_pc_i             (mem_pc),
    .mem_branch_address_i (mem_branch_address),
    .mem_address_i        (mem_address),
    .exc_start_o          (exc_start),
    .exc_code_o           (exc_code),
    .exc_epc_o            (exc_epc),
    .exc_bd_o             (exc_bd),
    .exc_vector_o         (exc_vector),
    .exc_badvaddr_o       (exc_badvaddr),
    .exc_badvaddr_we_o    (exc_badvaddr_we),
    .pipeline_flush_o     (pipeline_flush),
    .irq_pending_o        (irq_pending)
  );

  typedef struct {
    logic [6:0]  exc;
    logic [1:0]  br;
    logic [31:0] pc;
    logic [31:0] baddr;
    logic [31:0] addr;
    logic        bev;
    logic        ie;
    logic [7:0]  im;
    logic [1:0]  sw;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic [31:0] vec;
    logic        we;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    interrupt_vector   = '0;
    sr_ie              = 1'b0;
    sr_im              = '0;
    sr_bev             = 1'b0;
    cause_ip_sw        = '0;
    mem_stall          = 1'b0;
    mem_exc            = '0;
    mem_branched       = '0;
    mem_pc             = '0;
    mem_branch_address = '0;
    mem_address        = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (pipeline_flush && n < 20) begin
      tick();
      n++;
    end
    chk("drain_flush", {31'd0, pipeline_flush}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  n;
    bit  restart;
    mem_exc            = v.exc;
    mem_branched       = v.br;
    mem_pc             = v.pc;
    mem_branch_address = v.baddr;
    mem_address        = v.addr;
    sr_bev             = v.bev;
    sr_ie              = v.ie;
    sr_im              = v.im;
    cause_ip_sw        = v.sw;
    tick();
    set_idle();
    chk($sformatf("v%0d_start", idx), {31'd0, exc_start}, 32'd1);
    chk($sformatf("v%0d_code", idx), {27'd0, exc_code}, {27'd0, v.code});
    chk($sformatf("v%0d_epc", idx), exc_epc, v.epc);
    chk($sformatf("v%0d_bd", idx), {31'd0, exc_bd}, {31'd0, v.bd});
    chk($sformatf("v%0d_vector", idx), exc_vector, v.vec);
    chk($sformatf("v%0d_bv_we", idx), {31'd0, exc_badvaddr_we}, {31'd0, v.we});
    if (v.we) chk($sformatf("v%0d_badvaddr", idx), exc_badvaddr, v.addr);
    chk($sformatf("v%0d_flush_entry", idx), {31'd0, pipeline_flush}, 32'd1);
    n = 0;
    restart = 1'b0;
    while (pipeline_flush && n < 20) begin
      tick();
      if (exc_start) restart = 1'b1;
      if (pipeline_flush) n++;
    end
    chk($sformatf("v%0d_flush_len", idx), n, 32'd2);
    chk($sformatf("v%0d_single_pulse", idx), {31'd0, restart}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    //                exc         br    pc            baddr         addr          bev   ie    im     sw     code   epc           bd    vec           we
    tbl[0]  = '{7'b0010000, 2'd0, 32'h80001000, 32'h0,        32'h0,        1'b0, 1'b0, 8'h00, 2'b00, 5'd8,  32'h80000FFC, 1'b0, 32'h80000080, 1'b0};
    tbl[1]  = '{7'b1000001, 2'd2, 32'h00000004, 32'h0,        32'h00001235, 1'b0, 1'b0, 8'h00, 2'b00, 5'd4,  32'hFFFFFFFC, 1'b1, 32'h80000080, 1'b1};
    tbl[2]  = '{7'b0100000, 2'd1, 32'h00400010, 32'h0,        32'hDEAD0003, 1'b1, 1'b0, 8'h00, 2'b00, 5'd5,  32'h0040000C, 1'b0, 32'hBFC00180, 1'b1};
    tbl[3]  = '{7'b0001000, 2'd0, 32'h00000100, 32'h0,        32'h0,        1'b0, 1'b0, 8'h00, 2'b00, 5'd9,  32'h000000FC, 1'b0, 32'h80000080, 1'b0};
    tbl[4]  = '{7'b0000101, 2'd2, 32'h00002000, 32'h0,        32'h0,        1'b0, 1'b0, 8'h00, 2'b00, 5'd10, 32'h00001FF8, 1'b1, 32'h80000080, 1'b0};
    tbl[5]  = '{7'b0000011, 2'd0, 32'h00000010, 32'h0,        32'h0,        1'b0, 1'b0, 8'h00, 2'b00, 5'd11, 32'h0000000C, 1'b0, 32'h80000080, 1'b0};
    tbl[6]  = '{7'b0000001, 2'd3, 32'h00000020, 32'h0,        32'h0,        1'b0, 1'b0, 8'h00, 2'b00, 5'd12, 32'h0000001C, 1'b0, 32'h80000080, 1'b0};
    tbl[7]  = '{7'b0010000, 2'd1, 32'h80000100, 32'h0,        32'h0,        1'b1, 1'b1, 8'h01, 2'b01, 5'd8,  32'h800000FC, 1'b0, 32'hBFC00180, 1'b0};
    tbl[8]  = '{7'b0000000, 2'd0, 32'h80000200, 32'h0,        32'h0,        1'b0, 1'b1, 8'h01, 2'b01, 5'd0,  32'h80000200, 1'b0, 32'h80000080, 1'b0};
    tbl[9]  = '{7'b0000000, 2'd1, 32'h00000300, 32'h0,        32'h0,        1'b0, 1'b1, 8'h02, 2'b10, 5'd0,  32'h000002FC, 1'b1, 32'h80000080, 1'b0};
    tbl[10] = '{7'b0000000, 2'd2, 32'h00000400, 32'h00009000, 32'h0,        1'b1, 1'b1, 8'h03, 2'b11, 5'd0,  32'h00009000, 1'b0, 32'hBFC00180, 1'b0};

    rst_n = 1'b0;
    set_idle();
    tick();
    tick();
    chk("rst_start", {31'd0, exc_start}, 32'd0);
    chk("rst_flush", {31'd0, pipeline_flush}, 32'd0);
    chk("rst_code", {27'd0, exc_code}, 32'd0);
    chk("rst_epc", exc_epc, 32'd0);
    chk("rst_vector", exc_vector, 32'd0);
    chk("rst_irq_pending", {31'd0, irq_pending}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_start", {31'd0, exc_start}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_vec(tbl[i], i);
      tick();
    end

    // Interrupt through the synchroniser, blocked by stall, then re-taken while held.
    interrupt_vector = 6'b000001;
    sr_im            = 8'h04;
    sr_ie            = 1'b1;
    mem_stall        = 1'b1;
    mem_pc           = 32'h80000500;
    tick();
    chk("irq_pend_1cyc", {31'd0, irq_pending}, 32'd0);
    tick();
    chk("irq_pend_2cyc", {31'd0, irq_pending}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_no_start_%0d", i), {31'd0, exc_start}, 32'd0);
    end
    mem_stall = 1'b0;
    tick();
    chk("irq_start", {31'd0, exc_start}, 32'd1);
    chk("irq_code", {27'd0, exc_code}, 32'd0);
    chk("irq_epc", exc_epc, 32'h80000500);
    chk("irq_bd", {31'd0, exc_bd}, 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      if (exc_start) break;
    end
    chk("irq_retake_gap", n, 32'd4);
    set_idle();
    drain();
    tick(); tick(); tick();

    // Second fault during the flush window is dropped.
    mem_exc = 7'b0010000;
    mem_pc  = 32'h00001000;
    tick();
    chk("f6_start", {31'd0, exc_start}, 32'd1);
    mem_exc = 7'b0001000;
    mem_pc  = 32'h00002000;
    tick();
    chk("f6_flush1_no_start", {31'd0, exc_start}, 32'd0);
    tick();
    chk("f6_flush2_no_start", {31'd0, exc_start}, 32'd0);
    set_idle();
    tick();
    chk("f6_idle_flush", {31'd0, pipeline_flush}, 32'd0);
    tick();
    chk("f6_idle_no_start", {31'd0, exc_start}, 32'd0);
    chk("f6_code_held", {27'd0, exc_code}, 32'd8);
    chk("f6_epc_held", exc_epc, 32'h00000FFC);

    // Masked-by-IE interrupt stays silent until IE is set.
    cause_ip_sw = 2'b10;
    sr_im       = 8'h02;
    sr_ie       = 1'b0;
    mem_pc      = 32'h00003000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ie0_no_start_%0d", i), {31'd0, exc_start}, 32'd0);
    end
    chk("ie0_pending", {31'd0, irq_pending}, 32'd0);
    sr_ie = 1'b1;
    #1;
    chk("ie1_pending", {31'd0, irq_pending}, 32'd1);
    tick();
    chk("ie1_start", {31'd0, exc_start}, 32'd1);
    chk("ie1_code", {27'd0, exc_code}, 32'd0);
    chk("ie1_epc", exc_epc, 32'h00003000);
    set_idle();
    drain();
    tick();

    // Reset mid-flush, then a normal fault afterwards.
    mem_exc = 7'b0000001;
    mem_pc  = 32'h00000050;
    tick();
    set_idle();
    tick();
    chk("rf_in_flush", {31'd0, pipeline_flush}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rf_start", {31'd0, exc_start}, 32'd0);
    chk("rf_flush", {31'd0, pipeline_flush}, 32'd0);
    chk("rf_code", {27'd0, exc_code}, 32'd0);
    chk("rf_epc", exc_epc, 32'd0);
    chk("rf_vector", exc_vector, 32'd0);
    tick();
    chk("rf_flush_next", {31'd0, pipeline_flush}, 32'd0);
    rst_n = 1'b1;
    tick();
    mem_exc     = 7'b0100000;
    mem_pc      = 32'h00000060;
    mem_address = 32'h00000ABC;
    tick();
    set_idle();
    chk("rf_new_start", {31'd0, exc_start}, 32'd1);
    chk("rf_new_code", {27'd0, exc_code}, 32'd5);
    chk("rf_new_epc", exc_epc, 32'h0000005C);
    chk("rf_new_we", {31'd0, exc_badvaddr_we}, 32'd1);
    chk("rf_new_badvaddr", exc_badvaddr, 32'h00000ABC);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
